// File: rtl/aec_req_arbiter.sv
// aec_req_arbiter
//   Shares one ASCII expression evaluator among NREQ requesters. A requester
//   is granted round-robin, and its expression (chars up to '=') is collected
//   into a local buffer. The buffer is then replayed into the evaluator as a
//   gap-free burst of one char per cycle. The arbiter waits for the
//   evaluator's result strobe and returns the result, or an error, to the
//   granted requester.
//
// Ports
//   clk, rst      rising-edge clock, synchronous active-high reset
//   req_valid     per-requester char valid
//   req_char      packed chars, requester i on req_char[8i+:8]
//   req_ready     per-requester char accept (granted requester, LOAD only)
//   rsp_valid     one-cycle response pulse for the granted requester
//   rsp_result    evaluator result (0 on error), held until the next response
//   rsp_err       overflow, empty expression or timeout; held like rsp_result
//   eval_ready    evaluator start strobe, first burst cycle only
//   eval_ascii    char stream to the evaluator (8'h00 outside a burst)
//   eval_valid    evaluator result strobe
//   eval_result   evaluator result
//   busy          high in every state except IDLE
//
// Handshake: a char on req_char[8i+:8] transfers in any cycle where
//   req_valid[i] && req_ready[i]. The requester holds the char stable while
//   req_valid[i] is high and it has not been accepted. It may drop req_valid
//   between chars at any time. req_ready is combinational from the FSM state
//   and req_valid, and it never depends on req_char.
module aec_req_arbiter #(
  parameter int NREQ    = 4,
  parameter int MAX_LEN = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_char,
  output logic [NREQ-1:0]   req_ready,
  output logic [NREQ-1:0]   rsp_valid,
  output logic [6:0]        rsp_result,
  output logic              rsp_err,
  output logic              eval_ready,
  output logic [7:0]        eval_ascii,
  input  logic              eval_valid,
  input  logic [6:0]        eval_result,
  output logic              busy
);

  localparam int         GW    = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int         LW    = $clog2(MAX_LEN + 1);
  localparam int         BW    = 8 * MAX_LEN;
  localparam logic [7:0] CH_EQ = 8'h3D;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LOAD   = 3'd1,
    S_LAUNCH = 3'd2,
    S_WAIT   = 3'd3,
    S_RESP   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [GW-1:0]   rr_q, rr_d;
  logic [GW-1:0]   gnt_q, gnt_d;
  logic [LW-1:0]   len_q, len_d;
  logic [LW-1:0]   k_q, k_d;
  logic [BW-1:0]   buffer_q, buffer_d;
  logic [8:0]      timer_q, timer_d;

  logic [7:0]      eval_ascii_q, eval_ascii_d;
  logic            eval_ready_q, eval_ready_d;
  logic [NREQ-1:0] rsp_valid_q, rsp_valid_d;
  logic [6:0]      rsp_result_q, rsp_result_d;
  logic            rsp_err_q, rsp_err_d;
  logic            busy_q, busy_d;

  // Round-robin pick: rotate the request vector so the rr pointer sits at
  // bit 0, find the lowest set bit, then add the pointer back modulo NREQ.
  logic [2*NREQ-1:0] rot_req;
  logic [GW-1:0]     pick_off;
  logic [GW:0]       pick_sum;
  logic [GW-1:0]     pick;

  always_comb begin
    rot_req  = {req_valid, req_valid} >> rr_q;
    pick_off = '0;
    for (int j = NREQ - 1; j >= 0; j--) begin
      if (rot_req[j]) pick_off = GW'(j);
    end
    pick_sum = {1'b0, rr_q} + {1'b0, pick_off};
    if (pick_sum >= (GW+1)'(NREQ)) pick_sum = pick_sum - (GW+1)'(NREQ);
    pick = pick_sum[GW-1:0];
  end

  // Granted requester's valid and char, selected by shifting so that no
  // variable bit-select is needed.
  logic [NREQ-1:0]   gnt_oh_q, gnt_oh_d;
  logic [8*NREQ-1:0] char_sh;
  logic [7:0]        g_char;
  logic              g_valid;

  assign gnt_oh_q = {{(NREQ-1){1'b0}}, 1'b1} << gnt_q;
  assign gnt_oh_d = {{(NREQ-1){1'b0}}, 1'b1} << gnt_d;
  assign char_sh  = req_char >> {gnt_q, 3'b000};
  assign g_char   = char_sh[7:0];
  assign g_valid  = |(req_valid & gnt_oh_q);

  assign req_ready = (state_q == S_LOAD) ? (req_valid & gnt_oh_q) : '0;

  // Buffer access by shift and mask. The write position is len_q and the
  // burst read position is k_d.
  logic [BW-1:0] wr_mask;
  logic [BW-1:0] wr_data;
  logic [BW-1:0] rd_sh;
  logic [7:0]    rd_char;

  assign wr_mask = BW'(8'hFF) << {len_q, 3'b000};
  assign wr_data = BW'(g_char) << {len_q, 3'b000};
  assign rd_sh   = buffer_d >> {k_d, 3'b000};
  assign rd_char = rd_sh[7:0];

  always_comb begin
    state_d      = state_q;
    rr_d         = rr_q;
    gnt_d        = gnt_q;
    len_d        = len_q;
    k_d          = k_q;
    buffer_d     = buffer_q;
    timer_d      = timer_q;
    rsp_result_d = rsp_result_q;
    rsp_err_d    = rsp_err_q;

    case (state_q)
      S_IDLE: begin
        if (|req_valid) begin
          gnt_d   = pick;
          len_d   = '0;
          state_d = S_LOAD;
        end
      end

      S_LOAD: begin
        if (g_valid) begin
          if (g_char == CH_EQ) begin
            if (len_q == '0) begin
              // An empty expression never reaches the evaluator.
              rsp_result_d = '0;
              rsp_err_d    = 1'b1;
              state_d      = S_RESP;
            end else begin
              k_d     = '0;
              state_d = S_LAUNCH;
            end
          end else if (len_q == LW'(MAX_LEN)) begin
            // Overflowing char is dropped and the request fails.
            rsp_result_d = '0;
            rsp_err_d    = 1'b1;
            state_d      = S_RESP;
          end else begin
            buffer_d = (buffer_q & ~wr_mask) | wr_data;
            len_d    = len_q + 1'b1;
          end
        end
      end

      S_LAUNCH: begin
        // k runs 0..len, where the last step emits the terminating '='.
        if (k_q == len_q) begin
          timer_d = '0;
          state_d = S_WAIT;
        end else begin
          k_d = k_q + 1'b1;
        end
      end

      S_WAIT: begin
        // A result arriving in the timeout cycle still counts as a success.
        if (eval_valid) begin
          rsp_result_d = eval_result;
          rsp_err_d    = 1'b0;
          state_d      = S_RESP;
        end else if (timer_q == 9'(TIMEOUT - 1)) begin
          rsp_result_d = '0;
          rsp_err_d    = 1'b1;
          state_d      = S_RESP;
        end else begin
          timer_d = timer_q + 9'd1;
        end
      end

      S_RESP: begin
        rr_d    = (gnt_q == GW'(NREQ - 1)) ? '0 : gnt_q + 1'b1;
        state_d = S_IDLE;
      end

      default: state_d = S_IDLE;
    endcase

    // Outputs are registered from the next state, so each registered output
    // lines up with the state the FSM is in during that cycle.
    busy_d       = (state_d != S_IDLE);
    rsp_valid_d  = (state_d == S_RESP) ? gnt_oh_d : '0;
    eval_ready_d = (state_d == S_LAUNCH) && (k_d == '0);
    if (state_d == S_LAUNCH) begin
      eval_ascii_d = (k_d < len_d) ? rd_char : CH_EQ;
    end else begin
      eval_ascii_d = 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      rr_q         <= '0;
      gnt_q        <= '0;
      len_q        <= '0;
      k_q          <= '0;
      buffer_q     <= '0;
      timer_q      <= '0;
      eval_ascii_q <= 8'h00;
      eval_ready_q <= 1'b0;
      rsp_valid_q  <= '0;
      rsp_result_q <= '0;
      rsp_err_q    <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      rr_q         <= rr_d;
      gnt_q        <= gnt_d;
      len_q        <= len_d;
      k_q          <= k_d;
      buffer_q     <= buffer_d;
      timer_q      <= timer_d;
      eval_ascii_q <= eval_ascii_d;
      eval_ready_q <= eval_ready_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_result_q <= rsp_result_d;
      rsp_err_q    <= rsp_err_d;
      busy_q       <= busy_d;
    end
  end

  assign eval_ascii = eval_ascii_q;
  assign eval_ready = eval_ready_q;
  assign rsp_valid  = rsp_valid_q;
  assign rsp_result = rsp_result_q;
  assign rsp_err    = rsp_err_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_aec_req_arbiter.sv
// Directed bench for aec_req_arbiter. Expected evaluator bursts and
// responses are queued when a request is set up. They are popped and
// compared when the DUT emits them.
module tb_aec_req_arbiter;

  localparam int NREQ    = 4;
  localparam int MAX_LEN = 16;
  localparam int TIMEOUT = 255;
  localparam int RW      = NREQ + 8;

  logic              clk;
  logic              rst;
  logic [NREQ-1:0]   req_valid;
  logic [8*NREQ-1:0] req_char;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ-1:0]   rsp_valid;
  logic [6:0]        rsp_result;
  logic              rsp_err;
  logic              eval_ready;
  logic [7:0]        eval_ascii;
  logic              eval_valid;
  logic [6:0]        eval_result;
  logic              busy;

  aec_req_arbiter #(
    .NREQ    (NREQ),
    .MAX_LEN (MAX_LEN),
    .TIMEOUT (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_char    (req_char),
    .req_ready   (req_ready),
    .rsp_valid   (rsp_valid),
    .rsp_result  (rsp_result),
    .rsp_err     (rsp_err),
    .eval_ready  (eval_ready),
    .eval_ascii  (eval_ascii),
    .eval_valid  (eval_valid),
    .eval_result (eval_result),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: observed no end of run, expected finish before 500000");
    $fatal(1, "watchdog");
  end

  // ---------------- scoreboard state ----------------
  logic [7:0]    exp_char_q[$];
  logic [RW-1:0] exp_rsp_q[$];
  logic [6:0]    eval_res_q[$];

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [RW-1:0] mk_rsp(input int idx, input logic err, input logic [6:0] res);
    logic [NREQ-1:0] oh;
    oh = NREQ'(1) << idx;
    return {oh, err, res};
  endfunction

  // ---------------- requester / evaluator models ----------------
  string tx_s[NREQ];
  int    tx_p[NREQ];
  int    tx_gap[NREQ];
  bit    tx_gapped[NREQ];

  int         eval_cd = 0;
  logic [6:0] eval_res_next = '0;

  task automatic load(input int i, input string s, input bit gapped);
    tx_s[i]      = s;
    tx_p[i]      = 0;
    tx_gap[i]    = 0;
    tx_gapped[i] = gapped;
  endtask

  task automatic push_burst(input string s);
    for (int j = 0; j < s.len(); j++) exp_char_q.push_back(s[j]);
  endtask

  // One clock: sample handshakes, then update requester and evaluator drives
  // just after the rising edge.
  task automatic step();
    logic [NREQ-1:0] acc;
    @(negedge clk);
    acc = req_valid & req_ready;
    @(posedge clk);
    #1;
    eval_valid = 1'b0;
    if (eval_cd > 0) begin
      eval_cd--;
      if (eval_cd == 0) begin
        eval_valid  = 1'b1;
        eval_result = eval_res_next;
      end
    end
    for (int i = 0; i < NREQ; i++) begin
      if (acc[i]) begin
        tx_p[i]++;
        if (tx_gapped[i]) tx_gap[i] = $urandom_range(1, 3);
      end
      if (tx_gap[i] > 0) begin
        req_valid[i] = 1'b0;
        tx_gap[i]--;
      end else if (tx_p[i] < tx_s[i].len()) begin
        req_valid[i]         = 1'b1;
        req_char[8*i +: 8]   = tx_s[i][tx_p[i]];
      end else begin
        req_valid[i] = 1'b0;
      end
    end
  endtask

  // ---------------- monitor ----------------
  int         cyc = 0;
  int         eq_cyc = 0;
  bit         in_burst = 0;
  bit         ignore_eval = 0;
  bit         chk_to = 0;
  logic [7:0] exp_c;
  logic [RW-1:0] exp_r;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      in_burst = 0;
    end else begin
      if (!ignore_eval) begin
        if (eval_ready) begin
          check("eval_ready_once", {31'd0, in_burst}, 32'd0);
          in_burst = 1;
        end
        if (in_burst) begin
          exp_c = (exp_char_q.size() > 0) ? exp_char_q.pop_front() : 8'hFF;
          check("eval_ascii", {24'd0, eval_ascii}, {24'd0, exp_c});
          if (eval_ascii == 8'h3D) begin
            in_burst = 0;
            eq_cyc   = cyc;
            if (eval_res_q.size() > 0) begin
              eval_res_next = eval_res_q.pop_front();
              eval_cd       = 3;
            end
          end
        end else if (eval_ascii != 8'h00) begin
          check("eval_idle_ascii", {24'd0, eval_ascii}, 32'd0);
        end
      end
      if (rsp_valid != '0) begin
        if (exp_rsp_q.size() == 0) begin
          check("unexpected_rsp", 32'(rsp_valid), 32'd0);
        end else begin
          exp_r = exp_rsp_q.pop_front();
          check("rsp", 32'({rsp_valid, rsp_err, rsp_result}), 32'(exp_r));
          if (chk_to) begin
            check("timeout_latency", 32'(cyc - eq_cyc), 32'(TIMEOUT + 1));
            chk_to = 0;
          end
        end
      end
    end
  end

  task automatic run_done(input string tag, input int budget);
    int n;
    n = 0;
    while ((exp_rsp_q.size() != 0 || exp_char_q.size() != 0) && n < budget) begin
      step();
      n++;
    end
    check(tag, 32'(exp_rsp_q.size() + exp_char_q.size()), 32'd0);
    repeat (2) step();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst         = 1'b1;
    req_valid   = '0;
    req_char    = '0;
    eval_valid  = 1'b0;
    eval_result = '0;
    for (int i = 0; i < NREQ; i++) load(i, "", 0);
    repeat (3) step();

    // Reset state
    check("rst_rsp_valid",  32'(rsp_valid), 32'd0);
    check("rst_rsp_result", 32'(rsp_result), 32'd0);
    check("rst_rsp_err",    32'(rsp_err), 32'd0);
    check("rst_eval_ready", 32'(eval_ready), 32'd0);
    check("rst_eval_ascii", 32'(eval_ascii), 32'd0);
    check("rst_busy",       32'(busy), 32'd0);
    check("rst_req_ready",  32'(req_ready), 32'd0);

    // Round robin: all four valid from reset, grants 0,1,2,3
    load(0, "1+1=", 0); load(1, "2+2=", 0); load(2, "3+3=", 0); load(3, "4+4=", 0);
    push_burst("1+1="); push_burst("2+2="); push_burst("3+3="); push_burst("4+4=");
    eval_res_q.push_back(7'd2); eval_res_q.push_back(7'd4);
    eval_res_q.push_back(7'd6); eval_res_q.push_back(7'd8);
    exp_rsp_q.push_back(mk_rsp(0, 0, 7'd2)); exp_rsp_q.push_back(mk_rsp(1, 0, 7'd4));
    exp_rsp_q.push_back(mk_rsp(2, 0, 7'd6)); exp_rsp_q.push_back(mk_rsp(3, 0, 7'd8));
    step();
    rst = 1'b0;
    run_done("rr_all_four", 300);

    // Single request: rr now 0, then serve 1 alone so rr moves to 2
    load(1, "9-1=", 0);
    push_burst("9-1="); eval_res_q.push_back(7'd8);
    exp_rsp_q.push_back(mk_rsp(1, 0, 7'd8));
    run_done("rr_req1", 100);

    // Requests 0 and 2 together: 2 wins, then 0
    load(0, "2*3=", 0); load(2, "8/2=", 0);
    push_burst("8/2="); push_burst("2*3=");
    eval_res_q.push_back(7'd4); eval_res_q.push_back(7'd6);
    exp_rsp_q.push_back(mk_rsp(2, 0, 7'd4)); exp_rsp_q.push_back(mk_rsp(0, 0, 7'd6));
    run_done("rr_2_then_0", 200);

    // Single request, basic flow
    load(0, "3+4=", 0);
    push_burst("3+4="); eval_res_q.push_back(7'd7);
    exp_rsp_q.push_back(mk_rsp(0, 0, 7'd7));
    run_done("single_req0", 100);
    check("hold_result", 32'(rsp_result), 32'd7);
    check("idle_busy", 32'(busy), 32'd0);

    // Gapped requester input, burst must still be gap-free
    load(1, "(1+2)*3=", 1);
    push_burst("(1+2)*3="); eval_res_q.push_back(7'd9);
    exp_rsp_q.push_back(mk_rsp(1, 0, 7'd9));
    run_done("gapped_req1", 300);

    // Overflow: 17 digits, no '='; evaluator must stay untouched
    load(3, "12345678901234567", 0);
    exp_rsp_q.push_back(mk_rsp(3, 1, 7'd0));
    run_done("overflow", 200);

    // Lone '='
    load(2, "=", 0);
    exp_rsp_q.push_back(mk_rsp(2, 1, 7'd0));
    run_done("empty_expr", 50);

    // Timeout: no evaluator result queued
    load(0, "5*5=", 0);
    push_burst("5*5=");
    exp_rsp_q.push_back(mk_rsp(0, 1, 7'd0));
    chk_to = 1;
    run_done("timeout", 400);
    check("timeout_checked", 32'(chk_to), 32'd0);
    // Late evaluator strobe in IDLE must be ignored
    eval_result = 7'd99;
    eval_valid  = 1'b1;
    step();
    repeat (3) step();
    check("late_eval_result", 32'(rsp_result), 32'd0);
    check("late_eval_err",    32'(rsp_err), 32'd1);
    check("late_eval_busy",   32'(busy), 32'd0);

    // Reset in the middle of a burst
    ignore_eval = 1;
    load(0, "1+2+3+4=", 0);
    for (int n = 0; n < 200 && !eval_ready; n++) step();
    check("mid_launch_seen", 32'(eval_ready), 32'd1);
    step();
    rst = 1'b1;
    step();
    check("abort_eval_ascii", 32'(eval_ascii), 32'd0);
    check("abort_eval_ready", 32'(eval_ready), 32'd0);
    check("abort_busy",       32'(busy), 32'd0);
    check("abort_rsp_valid",  32'(rsp_valid), 32'd0);
    rst = 1'b0;
    ignore_eval = 0;
    repeat (300) step();

    // Request after the abort behaves normally
    load(0, "3+4=", 0);
    push_burst("3+4="); eval_res_q.push_back(7'd7);
    exp_rsp_q.push_back(mk_rsp(0, 0, 7'd7));
    run_done("after_abort", 100);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
